// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel/line counters with registered sync, blank and frame strobes.
// Decode is taken from the next-state counter values, so every output lines up with DrawX/DrawY.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int FC_W     = 8
) (
  input  logic            vga_clk,
  input  logic            reset,
  output logic            hs,
  output logic            vs,
  output logic            blank,
  output logic [9:0]      DrawX,
  output logic [9:0]      DrawY,
  output logic            frame_start,
  output logic            vblank_start,
  output logic [FC_W-1:0] frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  generate
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_totals
      $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
    end
  endgenerate

  localparam logic [9:0]  X_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0]  Y_LAST = 10'(V_TOTAL - 1);
  // 11-bit bounds so a window ending exactly at 1024 still compares correctly
  localparam logic [10:0] X_VIS  = 11'(H_ACTIVE);
  localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] Y_VIS  = 11'(V_ACTIVE);
  localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0]      x_q, x_d;
  logic [9:0]      y_q, y_d;
  logic [10:0]     x_ext, y_ext;
  logic            hs_q, hs_d;
  logic            vs_q, vs_d;
  logic            blank_q, blank_d;
  logic            fs_q, fs_d;
  logic            vbs_q, vbs_d;
  logic [FC_W-1:0] fc_q, fc_d;

  always_comb begin
    x_d = x_q + 10'd1;
    y_d = y_q;
    if (x_q == X_LAST) begin
      x_d = '0;
      y_d = (y_q == Y_LAST) ? '0 : y_q + 10'd1;
    end

    x_ext   = {1'b0, x_d};
    y_ext   = {1'b0, y_d};
    blank_d = (x_ext < X_VIS) && (y_ext < Y_VIS);
    hs_d    = !((x_ext >= HS_BEG) && (x_ext < HS_END));
    vs_d    = !((y_ext >= VS_BEG) && (y_ext < VS_END));
    fs_d    = (x_d == '0) && (y_d == '0);
    vbs_d   = (x_d == '0) && (y_ext == Y_VIS);
    fc_d    = fs_d ? fc_q + FC_W'(1) : fc_q;
  end

  // Reset parks the raster on the last pixel of a frame so release starts cleanly at (0,0)
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      x_q     <= X_LAST;
      y_q     <= Y_LAST;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      blank_q <= 1'b0;
      fs_q    <= 1'b0;
      vbs_q   <= 1'b0;
      fc_q    <= '1;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      blank_q <= blank_d;
      fs_q    <= fs_d;
      vbs_q   <= vbs_d;
      fc_q    <= fc_d;
    end
  end

  assign DrawX        = x_q;
  assign DrawY        = y_q;
  assign hs           = hs_q;
  assign vs           = vs_q;
  assign blank        = blank_q;
  assign frame_start  = fs_q;
  assign vblank_start = vbs_q;
  assign frame_count  = fc_q;

endmodule
